// File: rtl/rng_word_collector.sv
// Consumer end of the ring-oscillator RNG bit interface.
// Synchronizes the asynchronous done/bit pair, packs bits LSB-first into words,
// runs a repetition-count health test and hands words out over valid/ready.
module rng_word_collector #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned REP_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_in,
  input  logic             rnd_bit_in,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             health_fail
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned RunW = $clog2(REP_LIMIT + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);
  localparam logic [RunW-1:0] RunLim  = RunW'(REP_LIMIT);

  typedef enum logic [0:0] {StCollect, StFail} state_e;

  state_e           state_q;
  logic             d_s1_q, d_s2_q, d_s3_q;
  logic             b_s1_q, b_s2_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [RunW-1:0]  run_q;
  logic             prev_q;
  logic [WIDTH-1:0] shreg_q;

  logic             capture;
  logic [RunW-1:0]  run_nxt;
  logic             trip;
  logic             last_bit;
  logic [WIDTH-1:0] word_nxt;
  logic             complete;

  // Two-flop synchronizers plus a third done flop for rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_s1_q <= 1'b0;
      d_s2_q <= 1'b0;
      d_s3_q <= 1'b0;
      b_s1_q <= 1'b0;
      b_s2_q <= 1'b0;
    end else begin
      d_s1_q <= done_in;
      d_s2_q <= d_s1_q;
      d_s3_q <= d_s2_q;
      b_s1_q <= rnd_bit_in;
      b_s2_q <= b_s1_q;
    end
  end

  // Next run count, trip detect and the word as it would look after this capture.
  always_comb begin
    capture = d_s2_q & ~d_s3_q;
    run_nxt = RunW'(1);
    // A zero run count marks "no previous bit since rst/clear".
    if ((run_q != '0) && (b_s2_q == prev_q)) begin
      run_nxt = (run_q == RunLim) ? run_q : run_q + RunW'(1);
    end
    trip     = (run_nxt == RunLim);
    last_bit = (bit_cnt_q == LastIdx);
    word_nxt = shreg_q;
    word_nxt[bit_cnt_q] = b_s2_q;
    complete = capture && !clear && (state_q == StCollect) && !trip && last_bit;
  end

  // Collector FSM: packing, repetition test and sticky health flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      health_fail <= 1'b0;
      bit_cnt_q   <= '0;
      run_q       <= '0;
      prev_q      <= 1'b0;
      shreg_q     <= '0;
    end else if (clear) begin
      state_q     <= StCollect;
      health_fail <= 1'b0;
      bit_cnt_q   <= '0;
      run_q       <= '0;
      prev_q      <= 1'b0;
    end else if (capture) begin
      unique case (state_q)
        StCollect: begin
          if (trip) begin
            // Tripping bit and partial word are both discarded.
            state_q     <= StFail;
            health_fail <= 1'b1;
            bit_cnt_q   <= '0;
          end else begin
            shreg_q   <= word_nxt;
            prev_q    <= b_s2_q;
            run_q     <= run_nxt;
            bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CntW'(1);
          end
        end
        StFail: begin
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  // Output handshake; a completed word is dropped only when the held one is not taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (complete) begin
        if (!out_valid || out_ready) begin
          out_data  <= word_nxt;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clear) begin
        overrun <= 1'b0;
      end else if (complete && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rng_word_collector.sv
// Bench for rng_word_collector: directed scenarios plus randomized bit pulses,
// all checked every cycle against a word-level behavioural model.
module tb_rng_word_collector;

  localparam int unsigned W   = 8;
  localparam int unsigned REP = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done_in = 1'b0;
  logic         rnd_bit_in = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         overrun;
  logic         health_fail;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;

  rng_word_collector #(
    .WIDTH     (W),
    .REP_LIMIT (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .done_in     (done_in),
    .rnd_bit_in  (rnd_bit_in),
    .clear       (clear),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: history of done/bit samples per edge, bit list as an integer.
  bit dh[$];
  bit bh[$];
  int m_data, m_acc, m_nbits, m_run;
  bit m_valid, m_ovr, m_fail, m_prev;

  always @(posedge clk) begin
    bit cap, b, done_word;
    int word;
    if (rst) begin
      m_data = 0; m_valid = 0; m_ovr = 0; m_fail = 0;
      m_acc = 0; m_nbits = 0; m_run = 0; m_prev = 0;
      dh.delete(); bh.delete();
      for (int i = 0; i < 3; i++) begin dh.push_back(1'b0); bh.push_back(1'b0); end
      chk_en = 1'b1;
    end else begin
      // Capture happens two edges after done is first sampled high.
      cap = dh[$-1] && !dh[$-2];
      b   = bh[$-1];
      done_word = 1'b0;
      word = 0;
      if (clear) begin
        m_fail = 0; m_acc = 0; m_nbits = 0; m_run = 0; m_ovr = 0;
      end else if (cap && !m_fail) begin
        m_run  = (m_run > 0 && b == m_prev) ? m_run + 1 : 1;
        m_prev = b;
        if (m_run >= REP) begin
          m_fail = 1; m_acc = 0; m_nbits = 0;
        end else begin
          m_acc = m_acc | (int'(b) << m_nbits);
          m_nbits++;
          if (m_nbits == W) begin
            done_word = 1'b1; word = m_acc; m_acc = 0; m_nbits = 0;
          end
        end
      end
      if (done_word) begin
        if (!m_valid || out_ready) begin m_data = word; m_valid = 1; end
        else m_ovr = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      dh.push_back(done_in); bh.push_back(rnd_bit_in);
      if (dh.size() > 4) begin void'(dh.pop_front()); void'(bh.pop_front()); end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("health_fail", 32'(health_fail), 32'(m_fail));
    end
  end

  task automatic tick_rand();
    if (rand_mode) begin
      out_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 59) == 0);
    end
  endtask

  task automatic send_bit(input bit b, input int hi = 3, input int lo = 3);
    @(negedge clk); done_in = 1'b1; rnd_bit_in = b; tick_rand();
    repeat (hi - 1) begin @(negedge clk); tick_rand(); end
    @(negedge clk); done_in = 1'b0; rnd_bit_in = 1'($urandom_range(0, 1)); tick_rand();
    repeat (lo - 1) begin @(negedge clk); tick_rand(); end
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  initial begin
    // Reset with done_in toggling.
    @(negedge clk); done_in = 1'b1;
    @(negedge clk); done_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_hf", 32'(health_fail), 32'h0);
    repeat (3) @(negedge clk);

    // Packing 0x4D with timed checks on the 8th pulse.
    send_bits(32'b0100_1101, 7);
    @(negedge clk); done_in = 1'b1; rnd_bit_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 chk("pack_valid_early", 32'(out_valid), 32'h0);
    @(posedge clk); #1 chk("pack_valid_rise", 32'(out_valid), 32'h1);
    chk("pack_data", 32'(out_data), 32'h4D);
    @(posedge clk); #1 chk("pack_valid_fall", 32'(out_valid), 32'h0);
    @(negedge clk); done_in = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: second word dropped, overrun sticky.
    out_ready = 1'b0;
    send_bits(32'h5555, 16);
    chk("bp_data", 32'(out_data), 32'h55);
    chk("bp_valid", 32'(out_valid), 32'h1);
    chk("bp_ovr", 32'(overrun), 32'h1);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_ovr_sticky", 32'(overrun), 32'h1);

    // Simultaneous accept and complete.
    pulse_clear();
    chk("clr_ovr", 32'(overrun), 32'h0);
    out_ready = 1'b0;
    send_bits(32'h55, 8);
    send_bits(32'hAA, 7);
    chk("sim_held", 32'(out_data), 32'h55);
    @(negedge clk); done_in = 1'b1; rnd_bit_in = 1'b1;
    @(negedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("sim_valid", 32'(out_valid), 32'h1);
    chk("sim_data", 32'(out_data), 32'hAA);
    chk("sim_ovr", 32'(overrun), 32'h0);
    @(negedge clk); done_in = 1'b0;
    repeat (2) @(negedge clk);

    // Health trip on the 6th capture.
    pulse_clear();
    send_bits(32'b01_1101, 5);
    chk("hf_before", 32'(health_fail), 32'h0);
    send_bit(1'b1);
    chk("hf_trip", 32'(health_fail), 32'h1);
    chk("hf_no_word", 32'(out_valid), 32'h0);
    send_bits(32'h5555, 10);
    chk("hf_ignored", 32'(out_data), 32'hAA);
    pulse_clear();
    chk("hf_cleared", 32'(health_fail), 32'h0);
    send_bits(32'h55, 8);
    chk("hf_recover", 32'(out_data), 32'h55);

    // Mid-word clear.
    send_bits(32'b011, 3);
    pulse_clear();
    send_bits(32'h4D, 8);
    chk("mid_clear", 32'(out_data), 32'h4D);

    // Randomized pulses with random backpressure and occasional clear.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_bit(1'($urandom_range(0, 1)), $urandom_range(3, 5), $urandom_range(3, 5));
    end
    rand_mode = 1'b0;
    clear = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
